timer_scheduler: RTL and testbench

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler_pkg.sv | 18 +
 rtl/timer_sched_channel.sv | 88 ++++++++
 rtl/timer_scheduler.sv | 147 ++++++++++++++
 tb/tb_timer_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_scheduler_pkg.sv
// Shared types for the timer scheduler: channel and arbiter state encodings
// and the channel mode constants.
package timer_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  typedef enum logic {
    A_IDLE  = 1'b0,
    A_GRANT = 1'b1
  } arb_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_sched_channel.sv
// One timer channel: period/mode registers, IDLE/RUN FSM and tick down-counter.
// expire_c pulses combinationally in the cycle whose tick ends the period.
module timer_sched_channel
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_period,
  input  logic             wr_oneshot,
  output logic             running,
  output logic             expire_c
);

  ch_state_t        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;

  // Configuration registers; a running count only sees a new period on reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      mode_q   <= MODE_PERIODIC;
    end else if (wr_en) begin
      period_q <= wr_period;
      mode_q   <= wr_oneshot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: stop, then start (restart), then tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!stop && start && (period_q != '0)) begin
          state_d = RUN;
          cnt_d   = period_q;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (start) begin
          cnt_d = period_q;
        end else if (tick) begin
          if (cnt_q == WIDTH'(1)) begin
            if (mode_q == MODE_ONESHOT) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = period_q;
            end
          end else if (cnt_q > WIDTH'(1)) begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    running  = (state_q == RUN);
    expire_c = (state_q == RUN) && tick && !stop && !start && (cnt_q == WIDTH'(1));
  end

endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel tick timer with a shared prescaler and a round-robin expiry
// arbiter. Define TIMER_SCHED_OVERRUN_EN to add the sticky ovr flags.
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_CH)-1:0] wr_ch,
  input  logic [WIDTH-1:0]          wr_period,
  input  logic                      wr_oneshot,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  output logic                      irq_valid,
  output logic [$clog2(NUM_CH)-1:0] irq_ch,
  input  logic                      irq_ack,
  output logic [NUM_CH-1:0]         running
`ifdef TIMER_SCHED_OVERRUN_EN
  ,
  output logic [NUM_CH-1:0]         ovr
`endif
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned PW   = $clog2(PRESCALE);

  logic [PW-1:0]     pre_q;
  logic              tick;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] clr_c;

  arb_state_t        arb_q, arb_d;
  logic [CH_W-1:0]   irq_ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   win_ch;
  logic              win_any;
  logic [CH_W:0]     rr_sum;

  // Prescaler: wraps at PRESCALE-1, frozen while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (en) begin
      pre_q <= (pre_q == PW'(PRESCALE - 1)) ? '0 : pre_q + PW'(1);
    end
  end

  assign tick = en && (pre_q == PW'(PRESCALE - 1));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_sched_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .start     (start[i]),
      .stop      (stop[i]),
      .wr_en     (wr_en && (wr_ch == CH_W'(i))),
      .wr_period (wr_period),
      .wr_oneshot(wr_oneshot),
      .running   (running[i]),
      .expire_c  (expire[i])
    );
  end

  // Pending events: a new expiry wins over a same-cycle acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~clr_c) | expire;
    end
  end

`ifdef TIMER_SCHED_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= '0;
    end else begin
      ovr <= ovr | (expire & pend_q);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q  <= A_IDLE;
      irq_ch <= '0;
      ptr_q  <= '0;
    end else begin
      arb_q  <= arb_d;
      irq_ch <= irq_ch_d;
      ptr_q  <= ptr_d;
    end
  end

  // Round-robin search starting at ptr, then arbiter next state
  always_comb begin
    arb_d    = arb_q;
    irq_ch_d = irq_ch;
    ptr_d    = ptr_q;
    win_ch   = ptr_q;
    win_any  = 1'b0;
    rr_sum   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      rr_sum = {1'b0, ptr_q} + (CH_W + 1)'(k);
      if (rr_sum >= (CH_W + 1)'(NUM_CH)) begin
        rr_sum = rr_sum - (CH_W + 1)'(NUM_CH);
      end
      if (!win_any && pend_q[rr_sum[CH_W-1:0]]) begin
        win_any = 1'b1;
        win_ch  = rr_sum[CH_W-1:0];
      end
    end
    case (arb_q)
      A_IDLE: begin
        if (win_any) begin
          arb_d    = A_GRANT;
          irq_ch_d = win_ch;
        end
      end
      A_GRANT: begin
        if (irq_ack) begin
          arb_d = A_IDLE;
          ptr_d = (irq_ch == CH_W'(NUM_CH - 1)) ? '0 : irq_ch + CH_W'(1);
        end
      end
      default: arb_d = A_IDLE;
    endcase
  end

  always_comb begin
    irq_valid = (arb_q == A_GRANT);
    clr_c     = '0;
    if ((arb_q == A_GRANT) && irq_ack) begin
      clr_c = NUM_CH'(1) << irq_ch;
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler (NUM_CH=4, WIDTH=16, PRESCALE=4),
// with a cycle-level behavioural model and directed scenarios.
module tb_timer_scheduler;

  localparam int NCH = 4;
  localparam int PS  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [15:0] wr_period = '0;
  logic        wr_oneshot = 1'b0;
  logic [3:0]  start = '0;
  logic [3:0]  stop = '0;
  logic        irq_valid;
  logic [1:0]  irq_ch;
  logic        irq_ack = 1'b0;
  logic [3:0]  running;
`ifdef TIMER_SCHED_OVERRUN_EN
  logic [3:0]  ovr;
`endif

  timer_scheduler #(
    .NUM_CH  (NCH),
    .WIDTH   (16),
    .PRESCALE(PS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_period (wr_period),
    .wr_oneshot(wr_oneshot),
    .start     (start),
    .stop      (stop),
    .irq_valid (irq_valid),
    .irq_ch    (irq_ch),
    .irq_ack   (irq_ack),
    .running   (running)
`ifdef TIMER_SCHED_OVERRUN_EN
    ,
    .ovr       (ovr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_pre = 0;
  int       m_left[NCH];
  int       m_per[NCH];
  bit       m_run[NCH];
  bit       m_os[NCH];
  bit [3:0] m_pend = '0;
  bit [3:0] m_ovr = '0;
  bit       m_valid = 1'b0;
  int       m_ch = 0;
  int       m_ptr = 0;

  task automatic model_reset();
    m_pre = 0; m_pend = '0; m_ovr = '0; m_valid = 0; m_ch = 0; m_ptr = 0;
    for (int i = 0; i < NCH; i++) begin
      m_left[i] = 0; m_per[i] = 0; m_run[i] = 0; m_os[i] = 0;
    end
  endtask

  task automatic model_step();
    bit       tk;
    bit [3:0] expd;
    bit [3:0] clr;
    bit       found;
    int       c;
    tk = en && (m_pre == PS - 1);
    if (en) m_pre = (m_pre + 1) % PS;
    expd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (stop[i]) begin
        m_run[i] = 0; m_left[i] = 0;
      end else if (!m_run[i]) begin
        if (start[i] && m_per[i] != 0) begin
          m_run[i] = 1; m_left[i] = m_per[i];
        end
      end else if (start[i]) begin
        m_left[i] = m_per[i];
      end else if (tk) begin
        if (m_left[i] == 1) begin
          expd[i] = 1'b1;
          if (m_os[i]) begin
            m_run[i] = 0; m_left[i] = 0;
          end else begin
            m_left[i] = m_per[i];
          end
        end else if (m_left[i] > 1) begin
          m_left[i] = m_left[i] - 1;
        end
      end
    end
    if (wr_en) begin
      m_per[wr_ch] = int'(wr_period);
      m_os[wr_ch]  = wr_oneshot;
    end
    clr = '0;
    if (m_valid) begin
      if (irq_ack) begin
        clr[m_ch] = 1'b1;
        m_ptr = (m_ch + 1) % NCH;
        m_valid = 0;
      end
    end else if (m_pend != 0) begin
      found = 0;
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (!found && m_pend[c]) begin
          found = 1; m_ch = c; m_valid = 1;
        end
      end
    end
    m_ovr  = m_ovr | (expd & m_pend);
    m_pend = (m_pend & ~clr) | expd;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        cyc++;
        model_step();
      end
    end
  end

  // ---------------- compare process + event log ----------------
  int ev_ch[$];
  int ev_cyc[$];
  int r1_fall = -1;
  bit prev_v = 0;
  bit prev_r1 = 0;

  initial begin
    logic [3:0] mr;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) mr[i] = m_run[i];
      chk("irq_valid", int'(irq_valid), int'(m_valid));
      chk("irq_ch", int'(irq_ch), m_ch);
      chk("running", int'(running), int'(mr));
`ifdef TIMER_SCHED_OVERRUN_EN
      chk("ovr", int'(ovr), int'(m_ovr));
`endif
      if (irq_valid && !prev_v) begin
        ev_ch.push_back(int'(irq_ch));
        ev_cyc.push_back(cyc);
      end
      if (!running[1] && prev_r1) r1_fall = cyc;
      prev_v  = irq_valid;
      prev_r1 = running[1];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = '0; stop = '0; wr_en = 1'b0; irq_ack = 1'b0;
    cycles(2);
    ev_ch.delete(); ev_cyc.delete(); r1_fall = -1;
    rst_n = 1'b1;
    en = 1'b1;
  endtask

  task automatic wr(input int ch, input int per, input bit os);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_period = 16'(per); wr_oneshot = os;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] m);
    start = m;
    @(negedge clk);
    start = '0;
  endtask

  task automatic pulse_stop(input logic [3:0] m);
    stop = m;
    @(negedge clk);
    stop = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    #1;
    chk("reset_irq_valid", int'(irq_valid), 0);
    chk("reset_irq_ch", int'(irq_ch), 0);
    chk("reset_running", int'(running), 0);
    @(negedge clk);

    // ch0 periodic period 3: events every 3 ticks = 12 clk
    do_reset();
    irq_ack = 1'b1;
    wr(0, 3, 1'b0);
    pulse_start(4'b0001);
    cycles(70);
    chk("t1_event_count_ge4", int'(ev_ch.size() >= 4), 1);
    for (int i = 0; i < ev_ch.size(); i++) chk("t1_irq_ch", ev_ch[i], 0);
    for (int i = 1; i < ev_cyc.size(); i++) chk("t1_period_clk", ev_cyc[i] - ev_cyc[i-1], 12);
    chk("t1_running0", int'(running[0]), 1);
    pulse_stop(4'b0001);
    cycles(4);

    // ch1 one-shot period 2: one event, running falls one cycle before irq_valid
    do_reset();
    irq_ack = 1'b1;
    wr(1, 2, 1'b1);
    pulse_start(4'b0010);
    cycles(40);
    chk("t2_event_count", ev_ch.size(), 1);
    if (ev_ch.size() >= 1) begin
      chk("t2_irq_ch", ev_ch[0], 1);
      chk("t2_fall_to_irq", ev_cyc[0] - r1_fall, 1);
    end
    chk("t2_running1", int'(running[1]), 0);

    // all channels period 1, started together, ack held
    do_reset();
    irq_ack = 1'b1;
    for (int i = 0; i < NCH; i++) wr(i, 1, 1'b0);
    pulse_start(4'b1111);
    cycles(30);
    chk("t3_event_count_ge4", int'(ev_ch.size() >= 4), 1);
    if (ev_ch.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_rr_order", ev_ch[i], i);
      for (int i = 1; i < 4; i++) chk("t3_bubble_gap", ev_cyc[i] - ev_cyc[i-1], 2);
    end
    pulse_stop(4'b1111);
    cycles(12);

    // ch2 stop in the same cycle as its expiring tick
    do_reset();
    irq_ack = 1'b1;
    wr(2, 1, 1'b0);
    pulse_start(4'b0100);
    found = 0;
    for (int i = 0; i < 2 * PS && found == 0; i++) begin
      if (m_pre == PS - 1) found = 1;
      else @(negedge clk);
    end
    chk("t4_tick_found", found, 1);
    pulse_stop(4'b0100);
    cycles(20);
    chk("t4_no_event", ev_ch.size(), 0);
    chk("t4_running2", int'(running[2]), 0);

    // ch0 period 1 with ack held low for >10 ticks: one merged event
    do_reset();
    irq_ack = 1'b0;
    wr(0, 1, 1'b0);
    pulse_start(4'b0001);
    cycles(44);
    chk("t5_event_count", ev_ch.size(), 1);
    if (ev_ch.size() >= 1) chk("t5_irq_ch", ev_ch[0], 0);
    chk("t5_irq_valid_held", int'(irq_valid), 1);
`ifdef TIMER_SCHED_OVERRUN_EN
    chk("t5_ovr0", int'(ovr[0]), 1);
`endif

    // asynchronous reset while an event is presented
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_irq_valid", int'(irq_valid), 0);
    chk("t6_async_irq_ch", int'(irq_ch), 0);
    chk("t6_async_running", int'(running), 0);
`ifdef TIMER_SCHED_OVERRUN_EN
    chk("t6_async_ovr", int'(ovr), 0);
`endif
    @(negedge clk);
    ev_ch.delete(); ev_cyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycles(30);
    chk("t6_no_event_after_reset", ev_ch.size(), 0);
    chk("t6_irq_valid", int'(irq_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
